oflow_core_fsm_reg_seq: RTL and testbench



---
 rtl/oflow_core_pkg.sv | 31 +++
 rtl/oflow_reg_pe_iter.sv | 36 +++
 rtl/oflow_core_fsm_reg_seq.sv | 110 +++++++++++
 tb/tb_oflow_core_fsm_reg_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/oflow_core_pkg.sv
// Shared constants and state type for the oflow core FSMs.
// Used by the top FSM, the FE FSM and the registration sequencer.
package oflow_core_pkg;

  localparam int PE_NUM          = 24;
  localparam int SET_LEN         = 8;
  localparam int REMAIN_BBOX_LEN = 5;
  localparam int PE_IDX_LEN      = 5;

  localparam logic [REMAIN_BBOX_LEN-1:0] PE_NUM_W =
    REMAIN_BBOX_LEN'(PE_NUM);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FE,
    ISSUE,
    WAIT_REG,
    SET_DONE
  } reg_seq_state_t;

  // Bboxes in the current set: a partial last set
  // when 0 < remain < PE_NUM, otherwise a full set.
  function automatic logic [REMAIN_BBOX_LEN-1:0] set_size(
    input logic [REMAIN_BBOX_LEN-1:0] remain
  );
    if (remain != '0 && remain < PE_NUM_W)
      return remain;
    return PE_NUM_W;
  endfunction

endpackage

// File: rtl/oflow_reg_pe_iter.sv
// PE iterator for the registration sequencer.
// Ports: clk, reset_N, load (clear + latch n_set_in), n_set_in,
//        adv (step to next PE), pe_sel, last_pe (pe_sel == n_set-1).
module oflow_reg_pe_iter
  import oflow_core_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_N,
  input  logic                       load,
  input  logic [REMAIN_BBOX_LEN-1:0] n_set_in,
  input  logic                       adv,
  output logic [PE_IDX_LEN-1:0]      pe_sel,
  output logic                       last_pe
);

  localparam logic [REMAIN_BBOX_LEN-1:0] ONE =
    REMAIN_BBOX_LEN'(1);

  logic [REMAIN_BBOX_LEN-1:0] n_set;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      pe_sel <= '0;
      n_set  <= '0;
    end else if (load) begin
      pe_sel <= '0;
      n_set  <= n_set_in;
    end else if (adv) begin
      pe_sel <= pe_sel + PE_IDX_LEN'(1);
    end
  end

  assign last_pe =
    (REMAIN_BBOX_LEN'(pe_sel) == n_set - ONE);

endmodule

// File: rtl/oflow_core_fsm_reg_seq.sv
// Registration sequencer: walks the PEs of each finished set
// through the shared registration engine, one bbox at a time.
// Ports: clk, reset_N, start_pe, num_of_sets, counter_of_remain_bboxes,
//        done_fe, done_reg -> start_reg, pe_sel, done_registration,
//        counter_set_reg, done_frame, busy.
module oflow_core_fsm_reg_seq
  import oflow_core_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_N,
  input  logic                       start_pe,
  input  logic [SET_LEN-1:0]         num_of_sets,
  input  logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes,
  input  logic                       done_fe,
  input  logic                       done_reg,
  output logic                       start_reg,
  output logic [PE_IDX_LEN-1:0]      pe_sel,
  output logic                       done_registration,
  output logic [SET_LEN-1:0]         counter_set_reg,
  output logic                       done_frame,
  output logic                       busy
);

  reg_seq_state_t state_q;
  reg_seq_state_t state_d;

  logic [SET_LEN-1:0] num_sets_q;
  logic               zero_frame_q;

  logic accept;
  logic zero_frame;
  logic iter_load;
  logic iter_adv;
  logic last_pe;
  logic last_set;

  assign accept     = (state_q == IDLE) && start_pe &&
                      (num_of_sets != '0);
  assign zero_frame = (state_q == IDLE) && start_pe &&
                      (num_of_sets == '0);
  assign iter_load  = (state_q == WAIT_FE) && done_fe;
  assign iter_adv   = (state_q == WAIT_REG) && done_reg &&
                      !last_pe;
  assign last_set   =
    (counter_set_reg + SET_LEN'(1) == num_sets_q);

  oflow_reg_pe_iter u_pe_iter (
    .clk      (clk),
    .reset_N  (reset_N),
    .load     (iter_load),
    .n_set_in (set_size(counter_of_remain_bboxes)),
    .adv      (iter_adv),
    .pe_sel   (pe_sel),
    .last_pe  (last_pe)
  );

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept)
          state_d = WAIT_FE;
      WAIT_FE:
        if (done_fe)
          state_d = ISSUE;
      ISSUE:
        state_d = WAIT_REG;
      WAIT_REG:
        if (done_reg)
          state_d = last_pe ? SET_DONE : ISSUE;
      SET_DONE:
        state_d = last_set ? IDLE : WAIT_FE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      num_sets_q      <= '0;
      counter_set_reg <= '0;
      zero_frame_q    <= 1'b0;
    end else begin
      zero_frame_q <= zero_frame;
      if (accept) begin
        num_sets_q      <= num_of_sets;
        counter_set_reg <= '0;
      end else if (state_q == SET_DONE &&
                   counter_set_reg != num_sets_q) begin
        counter_set_reg <= counter_set_reg + SET_LEN'(1);
      end
    end
  end

  // An empty frame completes one cycle after start_pe
  // without ever leaving IDLE.
  assign start_reg         = (state_q == ISSUE);
  assign done_registration = (state_q == SET_DONE);
  assign done_frame        =
    ((state_q == SET_DONE) && last_set) || zero_frame_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_oflow_core_fsm_reg_seq.sv
// Randomized bench for the registration sequencer.
// Expected behaviour comes from a per-set cycle timeline model.
module tb_oflow_core_fsm_reg_seq;
  import oflow_core_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset_N = 1'b0;
  logic                       start_pe = 1'b0;
  logic [SET_LEN-1:0]         num_of_sets = '0;
  logic [REMAIN_BBOX_LEN-1:0] remain = '0;
  logic                       done_fe = 1'b0;
  logic                       done_reg = 1'b0;
  logic                       start_reg;
  logic [PE_IDX_LEN-1:0]      pe_sel;
  logic                       done_registration;
  logic [SET_LEN-1:0]         counter_set_reg;
  logic                       done_frame;
  logic                       busy;

  int total = 0;
  int bad = 0;

  oflow_core_fsm_reg_seq dut (
    .clk                      (clk),
    .reset_N                  (reset_N),
    .start_pe                 (start_pe),
    .num_of_sets              (num_of_sets),
    .counter_of_remain_bboxes (remain),
    .done_fe                  (done_fe),
    .done_reg                 (done_reg),
    .start_reg                (start_reg),
    .pe_sel                   (pe_sel),
    .done_registration        (done_registration),
    .counter_set_reg          (counter_set_reg),
    .done_frame               (done_frame),
    .busy                     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int model_n(input int r);
    if (r > 0 && r < PE_NUM)
      return r;
    return PE_NUM;
  endfunction

  task automatic check_idle_outs(input string tag);
    check({tag, "_sr"}, start_reg, 0);
    check({tag, "_pe"}, pe_sel, 0);
    check({tag, "_dr"}, done_registration, 0);
    check({tag, "_cnt"}, counter_set_reg, 0);
    check({tag, "_df"}, done_frame, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Runs one frame; called and returns at a negedge.
  task automatic run_frame(input int nsets,
                           input int rems[3],
                           input int k,
                           input int lead,
                           input bit noise,
                           input bit sp_noise,
                           input int abort_set);
    int n;
    int len;
    int i;
    int j;
    num_of_sets = SET_LEN'(nsets);
    start_pe = 1'b1;
    step();
    start_pe = 1'b0;
    if (nsets == 0) begin
      check("zf_frame", done_frame, 1);
      check("zf_busy", busy, 0);
      check("zf_start", start_reg, 0);
      step();
      check("zf_pulse", done_frame, 0);
      check("zf_busy2", busy, 0);
      return;
    end
    check("go_busy", busy, 1);
    check("go_cnt", counter_set_reg, 0);
    for (int s = 0; s < nsets; s++) begin
      for (int w = 0; w < lead; w++) begin
        check("wfe_sr", start_reg, 0);
        check("wfe_dr", done_registration, 0);
        check("wfe_busy", busy, 1);
        done_reg = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        start_pe = sp_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
      end
      n = model_n(rems[s]);
      len = 1 + n * (k + 1);
      remain = REMAIN_BBOX_LEN'(rems[s]);
      done_fe = 1'b1;
      done_reg = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      for (int c = 1; c <= len; c++) begin
        remain = REMAIN_BBOX_LEN'($urandom_range(0, 31));
        if (s == abort_set && c == 2) begin
          reset_N = 1'b0;
          #1;
          check_idle_outs("abort");
          done_fe = 1'b0;
          done_reg = 1'b0;
          start_pe = 1'b0;
          step();
          step();
          reset_N = 1'b1;
          step();
          check("post_abort_busy", busy, 0);
          check("post_abort_df", done_frame, 0);
          return;
        end
        start_pe = sp_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (sp_noise)
          num_of_sets = SET_LEN'($urandom_range(0, 5));
        if (c == len) begin
          check("sd_dr", done_registration, 1);
          check("sd_sr", start_reg, 0);
          check("sd_cnt", counter_set_reg, s);
          check("sd_df", done_frame, s == nsets - 1);
          check("sd_busy", busy, 1);
          done_fe = 1'b0;
          done_reg = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end else begin
          i = (c - 1) / (k + 1);
          j = (c - 1) % (k + 1);
          check("bb_sr", start_reg, j == 0);
          check("bb_dr", done_registration, 0);
          check("bb_df", done_frame, 0);
          check("bb_busy", busy, 1);
          if (j == 0)
            check("bb_pe", pe_sel, i);
          if (j == k)
            done_reg = 1'b1;
          else if (j == 0 && noise)
            done_reg = 1'($urandom_range(0, 1));
          else
            done_reg = 1'b0;
        end
        step();
      end
      start_pe = 1'b0;
      done_reg = 1'b0;
      check("ps_cnt", counter_set_reg, s + 1);
      check("ps_dr", done_registration, 0);
      check("ps_sr", start_reg, 0);
      check("ps_pe", pe_sel, n - 1);
      check("ps_busy", busy, s != nsets - 1);
      check("ps_df", done_frame, 0);
    end
    step();
    check("end_busy", busy, 0);
    check("end_cnt", counter_set_reg, nsets);
    check("end_df", done_frame, 0);
  endtask

  initial begin
    int r[3];
    @(negedge clk);
    #1;
    check_idle_outs("rst");
    step();
    reset_N = 1'b1;
    step();
    check_idle_outs("rst_rel");

    run_frame(1, '{24, 0, 0}, 1, 5, 1'b0, 1'b0, -1);
    run_frame(3, '{31, 0, 12}, 2, 2, 1'b0, 1'b0, -1);
    run_frame(0, '{0, 0, 0}, 1, 0, 1'b0, 1'b0, -1);
    run_frame(2, '{5, 20, 0}, 3, 3, 1'b1, 1'b0, -1);
    run_frame(3, '{24, 24, 24}, 2, 1, 1'b0, 1'b0, 1);
    run_frame(1, '{7, 0, 0}, 1, 2, 1'b0, 1'b0, -1);
    run_frame(2, '{24, 10, 0}, 1, 0, 1'b0, 1'b1, -1);

    repeat (6) begin
      for (int q = 0; q < 3; q++)
        r[q] = $urandom_range(0, 31);
      run_frame($urandom_range(1, 3), r,
                $urandom_range(1, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
